// File: rtl/multicycle_shift_unit.sv
// Iterative RV32 shift unit: SLL/SRL/SRA/ROR, moving at most STEP bit positions per clock.
// Valid/ready on both sides; one request in flight at a time (IDLE -> SHIFT -> DONE).
module multicycle_shift_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH),
    parameter int STEP        = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [DATA_WIDTH-1:0]  SrcA,
    input  logic [SHAMT_WIDTH-1:0] Shamt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  Rd,
    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    // Two spare bits so both STEP and DATA_WIDTH fit alongside the shift count.
    localparam int            CW     = SHAMT_WIDTH + 2;
    localparam logic [CW-1:0] STEP_C = CW'(STEP);
    localparam logic [CW-1:0] DW_C   = CW'(DATA_WIDTH);

    state_t                  state_r, state_s;
    logic [1:0]              op_r, op_s;
    logic [DATA_WIDTH-1:0]   work_r, work_s;
    logic [SHAMT_WIDTH-1:0]  remaining_r, remaining_s;
    logic                    fill_r, fill_s;
    logic [DATA_WIDTH-1:0]   rd_r, rd_s;
    logic                    out_valid_r, out_valid_s;
    logic                    in_ready_r, in_ready_s;
    logic                    busy_r, busy_s;
    logic [CW-1:0]           rem_ext_s, step_s, rem_left_s;
    logic [DATA_WIDTH-1:0]   shifted_s;

    // One partial shift of v by s positions; SRA fills with the sign latched at accept.
    function automatic logic [DATA_WIDTH-1:0] shift_by(
        input logic [DATA_WIDTH-1:0] v,
        input logic [1:0]            o,
        input logic                  fill,
        input logic [CW-1:0]         s
    );
        logic [DATA_WIDTH-1:0] r;
        r = v;
        case (o)
            OP_SLL:  r = v << s;
            OP_SRL:  r = v >> s;
            OP_SRA:  r = (v >> s) | (fill ? ~({DATA_WIDTH{1'b1}} >> s) : {DATA_WIDTH{1'b0}});
            OP_ROR:  r = (v >> s) | (v << (DW_C - s));
            default: r = v;
        endcase
        return r;
    endfunction

    // Step size for this cycle and the resulting shifted value / leftover count.
    always_comb begin
        rem_ext_s  = {2'b00, remaining_r};
        step_s     = (rem_ext_s < STEP_C) ? rem_ext_s : STEP_C;
        rem_left_s = rem_ext_s - step_s;
        shifted_s  = shift_by(work_r, op_r, fill_r, step_s);
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        work_s      = work_r;
        remaining_s = remaining_r;
        fill_s      = fill_r;
        rd_s        = rd_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    op_s        = op;
                    work_s      = SrcA;
                    remaining_s = Shamt;
                    fill_s      = SrcA[DATA_WIDTH-1];
                    if (Shamt == {SHAMT_WIDTH{1'b0}}) begin
                        state_s = ST_DONE;
                        rd_s    = SrcA;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_s      = shifted_s;
                remaining_s = rem_left_s[SHAMT_WIDTH-1:0];
                if (rem_left_s == {CW{1'b0}}) begin
                    state_s = ST_DONE;
                    rd_s    = shifted_s;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        out_valid_s = (state_s == ST_DONE);
        in_ready_s  = (state_s == ST_IDLE);
        busy_s      = (state_s != ST_IDLE);
    end

    // State, datapath and handshake registers; reset abandons any in-flight shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_SLL;
            work_r      <= {DATA_WIDTH{1'b0}};
            remaining_r <= {SHAMT_WIDTH{1'b0}};
            fill_r      <= 1'b0;
            rd_r        <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            work_r      <= work_s;
            remaining_r <= remaining_s;
            fill_r      <= fill_s;
            rd_r        <= rd_s;
            out_valid_r <= out_valid_s;
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
        end
    end

    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign Rd        = rd_r;

endmodule

// File: tb/tb_multicycle_shift_unit.sv
// Directed and random bench for multicycle_shift_unit at STEP=8, STEP=1 and STEP=32.
module tb_multicycle_shift_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [1:0]  op        [3];
    logic [31:0] srca      [3];
    logic [4:0]  shamt     [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] rd        [3];
    logic        busy      [3];

    int checks;
    int errors;

    localparam int STEPS [3] = '{8, 1, 32};

    multicycle_shift_unit #(.DATA_WIDTH(32), .STEP(8)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op[0]), .SrcA(srca[0]), .Shamt(shamt[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .Rd(rd[0]), .busy(busy[0]));

    multicycle_shift_unit #(.DATA_WIDTH(32), .STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op[1]), .SrcA(srca[1]), .Shamt(shamt[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .Rd(rd[1]), .busy(busy[1]));

    multicycle_shift_unit #(.DATA_WIDTH(32), .STEP(32)) u_s32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .op(op[2]), .SrcA(srca[2]), .Shamt(shamt[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .Rd(rd[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] golden(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        logic [63:0] d;
        d = {a, a} >> s;
        case (o)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b11:   return $unsigned($signed(a) >>> s);
            default: return d[31:0];
        endcase
    endfunction

    // Issue one request on instance k, measure latency, check Rd, optionally take the result.
    task automatic run_txn(input int k, input logic [1:0] o, input logic [31:0] a,
                           input logic [4:0] s, input bit take, input string tag);
        int n;
        int lat;
        int exp_lat;
        logic [31:0] exp_rd;
        n = 0;
        while (in_ready[k] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s in_ready_timeout actual=%b required=1", tag, in_ready[k]);
        end
        op[k] = o; srca[k] = a; shamt[k] = s; in_valid[k] = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        op[k] = ~o; srca[k] = ~a; shamt[k] = ~s;
        while (out_valid[k] !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        exp_lat = (s == 5'd0) ? 1 : 1 + (int'(s) + STEPS[k] - 1) / STEPS[k];
        exp_rd  = golden(o, a, s);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency actual=%0d required=%0d", tag, lat, exp_lat);
        end
        checks++;
        if (rd[k] !== exp_rd) begin
            errors++;
            $display("FAIL %s rd actual=%h required=%h", tag, rd[k], exp_rd);
        end
        if (take) begin
            out_ready[k] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready[k] = 1'b0;
            checks++;
            if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
                errors++;
                $display("FAIL %s after_take actual=%b%b required=01", tag, out_valid[k], in_ready[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || rd[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset[%0d] actual=%b%b%b/%h required=100/00000000",
                         k, in_ready[k], out_valid[k], busy[k], rd[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [4:0]  s;
    } vec_t;

    task automatic test_directed();
        vec_t vecs [8];
        vecs = '{
            '{2'b01, 32'h0000_0010, 5'd2},
            '{2'b01, 32'h0000_0001, 5'd1},
            '{2'b01, 32'hFFFF_FFFF, 5'd4},
            '{2'b11, 32'h8000_0000, 5'd31},
            '{2'b11, 32'h4000_0000, 5'd31},
            '{2'b00, 32'h1234_5678, 5'd0},
            '{2'b10, 32'h0000_0001, 5'd1},
            '{2'b10, 32'h0000_00F0, 5'd12}
        };
        for (int i = 0; i < 8; i++) begin
            run_txn(0, vecs[i].o, vecs[i].a, vecs[i].s, 1'b1, $sformatf("directed%0d", i));
        end
    endtask

    task automatic test_backpressure();
        run_txn(0, 2'b01, 32'hF0F0_F0F0, 5'd4, 1'b0, "bp_issue");
        for (int c = 0; c < 5; c++) begin
            in_valid[0] = c[0];
            srca[0] = 32'hDEAD_0000 + 32'(c);
            shamt[0] = 5'd3;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || rd[0] !== 32'h0F0F_0F0F) begin
                errors++;
                $display("FAIL bp_hold%0d actual=%b%b/%h required=10/0f0f0f0f",
                         c, out_valid[0], in_ready[0], rd[0]);
            end
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || rd[0] !== 32'h0F0F_0F0F) begin
            errors++;
            $display("FAIL bp_release actual=%b%b/%h required=01/0f0f0f0f", out_valid[0], in_ready[0], rd[0]);
        end
        run_txn(0, 2'b00, 32'h0000_0001, 5'd8, 1'b1, "bp_next");
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        op[0] = 2'b00; srca[0] = 32'h0000_0001; shamt[0] = 5'd20; in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy actual=%b%b required=10", busy[0], in_ready[0]);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (out_valid[0] !== 1'b0 || rd[0] !== 32'h0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset actual=%b%b%b/%h required=010/00000000",
                     out_valid[0], in_ready[0], busy[0], rd[0]);
        end
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid[0] === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_no_output actual=%0d required=0", seen);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 25; i++) begin
                run_txn(k, 2'($urandom_range(3, 0)), $urandom, 5'($urandom_range(31, 0)), 1'b1,
                        $sformatf("rand_s%0d_%0d", STEPS[k], i));
            end
            run_txn(k, 2'b11, 32'h8765_4321, 5'd31, 1'b1, $sformatf("max_s%0d", STEPS[k]));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0; op[k] = 2'b00;
            srca[k] = 32'h0; shamt[k] = 5'd0;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
